// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the synchronous FIFO.
// Latency: n/a (constants only). Backpressure: n/a.
package sync_fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Pointer width for a power-of-two depth; never below one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, registered read port.
// Latency: rdata valid one cycle after re. Backpressure: none, the caller gates we/re.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [ptr_w(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    re,
   input  logic [ptr_w(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]        rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Array is deliberately left out of reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered dout; optional sticky overflow/underflow under SYNC_FIFO_ERR_FLAGS_EN.
// Latency: dout valid one cycle after an accepted rd_en. Backpressure: writes dropped while full, reads ignored while empty.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic             overflow,
   output logic             underflow
`endif
);

   localparam int             PW       = ptr_w(DEPTH);
   localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          wr_acc;
   logic          rd_acc;

   assign full   = (count == CNT_FULL);
   assign empty  = (count == '0);
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (din),
      .re    (rd_acc),
      .raddr (rd_ptr),
      .rdata (dout)
   );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   // Any attempt counts, including a write refused because a read took priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)  overflow  <= 1'b1;
         if (rd_en && empty) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic against a queue-based model.
// Flags are checked too when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

   localparam int W = 8;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         wr_en = 1'b0;
   logic         rd_en = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout;
   logic         full;
   logic         empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic         overflow;
   logic         underflow;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] m_dout = '0;
   logic         m_ovf  = 1'b0;
   logic         m_udf  = 1'b0;

   sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .din       (din),
      .dout      (dout),
      .full      (full),
      .empty     (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".dout"},  32'(dout),  32'(m_dout));
      check({tag, ".full"},  32'(full),  32'(q.size() == D));
      check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
      check({tag, ".udf"},   32'(underflow), 32'(m_udf));
`endif
   endtask

   // One clock with the given request; the model decides acceptance from occupancy alone.
   task automatic step(input string tag, input logic we, input logic re, input logic [W-1:0] d);
      bit do_wr;
      bit do_rd;
      wr_en = we;
      rd_en = re;
      din   = d;
      do_rd = re && (q.size() > 0);
      do_wr = we && (q.size() < D);
      if (we && q.size() == D) m_ovf = 1'b1;
      if (re && q.size() == 0) m_udf = 1'b1;
      @(posedge clk);
      #1;
      if (do_rd) m_dout = q.pop_front();
      if (do_wr) q.push_back(d);
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_state(tag);
   endtask

   // Assert reset between edges and confirm it takes effect without a clock.
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      check_state(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end expected end");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      q.delete();
      check_state("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // In-order readback of three words.
      step("w_aa", 1, 0, 8'hAA);
      step("w_bb", 1, 0, 8'hBB);
      step("w_cc", 1, 0, 8'hCC);
      for (int i = 0; i < 3; i++) step("rd3", 0, 1, '0);
      check("rd3_last", 32'(dout), 32'hCC);

      // Fill, drop FF while full, drain.
      for (int i = 0; i < D; i++) step("fill", 1, 0, W'(i));
      check("fill_full", 32'(full), 32'd1);
      step("w_ff_drop", 1, 0, 8'hFF);
      for (int i = 0; i < D; i++) begin
         step("drain", 0, 1, '0);
         check("drain_val", 32'(dout), 32'(i));
      end

      // Single write then single read.
      step("one_w", 1, 0, 8'hAA);
      step("one_r", 0, 1, '0);
      check("one_val", 32'(dout), 32'hAA);

      // Read on empty keeps dout.
      step("rd_empty", 0, 1, '0);
      check("rd_empty_hold", 32'(dout), 32'hAA);

      // Write 0..9: 8 and 9 dropped.
      for (int i = 0; i < 10; i++) step("w10", 1, 0, W'(i));
      for (int i = 0; i < D; i++) begin
         step("r10", 0, 1, '0);
         check("r10_val", 32'(dout), 32'(i));
      end
      step("r10_extra", 0, 1, '0);
      check("r10_hold", 32'(dout), 32'd7);

      // Both requests on full and on empty.
      step("both_empty", 1, 1, 8'h5A);
      for (int i = 0; i < D - 1; i++) step("refill", 1, 0, W'(8'h60 + i));
      step("both_full", 1, 1, 8'hEE);
      for (int i = 0; i < D - 1; i++) step("drain2", 0, 1, '0);

      apply_reset("rst_clr");
      // Four held entries, four cycles of simultaneous traffic, then reset mid-stream.
      for (int i = 0; i < 4; i++) step("hold4", 1, 0, W'(8'h10 + i));
      for (int i = 0; i < 4; i++) begin
         step("simul", 1, 1, W'(8'h20 + i));
         check("simul_val", 32'(dout), 32'(8'h10 + i));
         check("simul_cnt", 32'(q.size()), 32'd4);
      end
      apply_reset("rst_mid");
      check("rst_mid_dout", 32'(dout), 32'd0);

      // Random traffic with phases biased toward filling and draining.
      for (int i = 0; i < 3000; i++) begin
         int wp;
         wp = ((i / 200) % 2 == 0) ? 70 : 30;
         step("rand", ($urandom_range(99) < wp), ($urandom_range(99) >= wp - 20),
              W'($urandom));
         if ($urandom_range(999) == 0) apply_reset("rand_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: write request, sampled on the clk rising edge.
REQ-006 SHALL have port rd_en, input, 1 bit: read request, sampled on the clk rising edge.
REQ-007 SHALL have port din, input, WIDTH bits: write data.
REQ-008 SHALL have port dout, output, WIDTH bits: registered read data.
REQ-009 SHALL have port full, output, 1 bit: high when DEPTH entries are stored.
REQ-010 SHALL have port empty, output, 1 bit: high when 0 entries are stored.

Function
REQ-011 SHALL perform a write on an edge where wr_en=1 and full=0: din is stored at the write pointer, which then increments modulo DEPTH.
REQ-012 SHALL ignore a write while full=1: no storage change, no pointer or count change, no error.
REQ-013 SHALL perform a read on an edge where rd_en=1 and empty=0: dout is loaded from the read pointer on that same edge, so data is valid one cycle after rd_en, and the read pointer increments modulo DEPTH.
REQ-014 SHALL ignore a read while empty=1, with dout holding its previous value.
REQ-015 SHALL keep dout unchanged on every edge without an accepted read.
REQ-016 SHALL, when a write and a read are both accepted on one edge, perform both with the occupancy count unchanged.
REQ-017 SHALL, when full=1 and wr_en=rd_en=1, accept only the read.
REQ-018 SHALL, when empty=1 and wr_en=rd_en=1, accept only the write.
REQ-019 SHALL use read and write pointers of clog2(DEPTH) bits that wrap to 0 after DEPTH-1.
REQ-020 SHALL keep an occupancy count of clog2(DEPTH)+1 bits.
REQ-021 SHALL derive full (count==DEPTH) and empty (count==0) combinationally from the registered count, so the flags reflect the state immediately after each edge.
REQ-022 SHALL return data strictly in write order (first in, first out) across any number of pointer wraps.

Reset
REQ-023 SHALL, while rst=1, immediately set both pointers and the count to 0, dout to 0, empty to 1 and full to 0.
REQ-024 SHALL NOT reset the storage array; its contents are don't-care after reset.
REQ-025 SHALL discard all stored entries when reset is asserted mid-operation, with the FIFO reporting empty on release.

Configuration
REQ-026 SHALL, when macro SYNC_FIFO_ERR_FLAGS_EN is defined, add outputs overflow and underflow (1 bit each):
  - overflow: sticky, set by a write attempt while full.
  - underflow: sticky, set by a read attempt while empty.
  - both cleared only by rst.
REQ-027 SHALL, without SYNC_FIFO_ERR_FLAGS_EN, omit both ports and their logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the default WIDTH/DEPTH constants and a clog2-based pointer-width helper in package sync_fifo_pkg.
REQ-029 SHALL implement storage in sub-module sync_fifo_mem: DEPTH x WIDTH array, synchronous write, registered read output.
REQ-030 SHALL implement the pointers, count, flags and control logic in sync_fifo itself.

Verification
REQ-031 SHALL cover: write AA, BB, CC on consecutive edges, then three single-cycle reads -> dout AA, BB, CC in order; empty=1 at end.
REQ-032 SHALL cover: write 0..7 -> full=1; write FF while full -> dropped; eight reads -> 0..7; then empty=1, full=0.
REQ-033 SHALL cover: single write AA then one read -> dout=AA one cycle later; empty returns to 1, full=0.
REQ-034 SHALL cover: write 0..9 with DEPTH=8 -> 8 and 9 dropped; reading until empty -> exactly 0..7, then empty=1.
REQ-035 SHALL cover: read on empty after dout=AA -> dout stays AA, empty=1; with SYNC_FIFO_ERR_FLAGS_EN, underflow=1.
REQ-036 SHALL cover: hold 4 entries, assert wr_en=rd_en=1 for 4 cycles -> count stays 4, order preserved; assert rst mid-stream -> empty=1, dout=0 immediately.
